// File: rtl/rps_throw_capture_pkg.sv
// Shared throw and FSM-state encodings for the rock-paper-scissors front end.
package rps_throw_capture_pkg;

  localparam logic [2:0] THROW_NONE     = 3'b000;
  localparam logic [2:0] THROW_ROCK     = 3'b001;
  localparam logic [2:0] THROW_PAPER    = 3'b010;
  localparam logic [2:0] THROW_SCISSORS = 3'b100;

  typedef enum logic [1:0] {
    WAIT_PRESS   = 2'd0,
    CAPTURE      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rps_throw_capture_debouncer.sv
// Button debouncer: optional 2-flop sync (RPS_SYNC_EN), then a stable-count filter.
// Output flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

`ifdef RPS_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_i};
  end

  assign btn_s = sync_q[1];
`else
  assign btn_s = btn_i;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // The toggle fires at CNT_MAX, so the counter can never wrap.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (btn_s != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = ~db_q;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/rps_throw_capture.sv
// Debounces playButton and captures both one-hot throws once per clean press.
// Throw synchronizers exist only with RPS_SYNC_EN defined; all outputs are registered.
module rps_throw_capture
  import rps_throw_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] p1Throw,
  input  logic [2:0] p2Throw,
  input  logic       playButton,
  output logic [2:0] p1Latched,
  output logic [2:0] p2Latched,
  output logic       roundStrobe,
  output logic       roundValid,
  output logic       invalidThrow
);

  logic       db;
  logic [2:0] p1_s, p2_s;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .btn_i (playButton),
    .db_o  (db)
  );

`ifdef RPS_SYNC_EN
  logic [5:0] thr_s1_q, thr_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_s1_q <= '0;
      thr_s2_q <= '0;
    end else begin
      thr_s1_q <= {p2Throw, p1Throw};
      thr_s2_q <= thr_s1_q;
    end
  end

  assign p1_s = thr_s2_q[2:0];
  assign p2_s = thr_s2_q[5:3];
`else
  assign p1_s = p1Throw;
  assign p2_s = p2Throw;
`endif

  logic p1_ok, p2_ok;
  assign p1_ok = (p1_s == THROW_ROCK) || (p1_s == THROW_PAPER) || (p1_s == THROW_SCISSORS);
  assign p2_ok = (p2_s == THROW_ROCK) || (p2_s == THROW_PAPER) || (p2_s == THROW_SCISSORS);

  state_e     state_q;
  logic [2:0] p1_latched_q, p2_latched_q;
  logic       strobe_q, valid_q, invalid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_PRESS;
      p1_latched_q <= THROW_NONE;
      p2_latched_q <= THROW_NONE;
      strobe_q     <= 1'b0;
      valid_q      <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        WAIT_PRESS: begin
          if (db) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (p1_ok && p2_ok) begin
            p1_latched_q <= p1_s;
            p2_latched_q <= p2_s;
            valid_q      <= 1'b1;
            invalid_q    <= 1'b0;
            strobe_q     <= 1'b1;
          end else begin
            p1_latched_q <= THROW_NONE;
            p2_latched_q <= THROW_NONE;
            valid_q      <= 1'b0;
            invalid_q    <= 1'b1;
          end
          state_q <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!db) state_q <= WAIT_PRESS;
        end
        default: state_q <= WAIT_PRESS;
      endcase
    end
  end

  assign p1Latched    = p1_latched_q;
  assign p2Latched    = p2_latched_q;
  assign roundStrobe  = strobe_q;
  assign roundValid   = valid_q;
  assign invalidThrow = invalid_q;

endmodule

// File: tb/tb_rps_throw_capture.sv
// Bench for rps_throw_capture with DEBOUNCE_CYCLES=4; expected strobes queued at press time.
`timescale 1ns/1ps
module tb_rps_throw_capture;

  localparam int D = 4;
`ifdef RPS_SYNC_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = D + 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] p1Throw = 3'b000;
  logic [2:0] p2Throw = 3'b000;
  logic       playButton = 1'b0;
  logic [2:0] p1Latched, p2Latched;
  logic       roundStrobe, roundValid, invalidThrow;

  rps_throw_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .p1Throw      (p1Throw),
    .p2Throw      (p2Throw),
    .playButton   (playButton),
    .p1Latched    (p1Latched),
    .p2Latched    (p2Latched),
    .roundStrobe  (roundStrobe),
    .roundValid   (roundValid),
    .invalidThrow (invalidThrow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] p1;
    logic [2:0] p2;
    int         edge_n;
  } exp_t;

  typedef struct {
    logic [2:0] p1;
    logic [2:0] p2;
    logic       valid;
    logic [2:0] e1;
    logic [2:0] e2;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued press.
  always @(negedge clk) begin
    if (!reset) begin
      check("flags_exclusive", {31'd0, roundValid & invalidThrow}, 32'd0);
      if (roundStrobe === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check("strobe_latency", cyc - sb_e.edge_n, LAT);
          check("strobe_p1", {29'd0, p1Latched}, {29'd0, sb_e.p1});
          check("strobe_p2", {29'd0, p2Latched}, {29'd0, sb_e.p2});
          check("strobe_valid", {31'd0, roundValid}, 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
    check("scoreboard_drain", sb_q.size(), 32'd0);
  endtask

  task automatic release_btn();
    playButton = 1'b0;
    tick(2 * D + 8);
    drain();
  endtask

  task automatic press(input logic [2:0] a, input logic [2:0] b, input logic valid, input int hold);
    p1Throw = a;
    p2Throw = b;
    tick(3);
    playButton = 1'b1;
    if (valid) sb_q.push_back('{p1: a, p2: b, edge_n: cyc + 1});
    tick(hold);
    release_btn();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p1"}, {29'd0, p1Latched}, 32'd0);
    check({tag, "_p2"}, {29'd0, p2Latched}, 32'd0);
    check({tag, "_strobe"}, {31'd0, roundStrobe}, 32'd0);
    check({tag, "_valid"}, {31'd0, roundValid}, 32'd0);
    check({tag, "_invalid"}, {31'd0, invalidThrow}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 3'b100, 1'b1, 3'b001, 3'b100};
    vecs[1] = '{3'b010, 3'b001, 1'b1, 3'b010, 3'b001};
    vecs[2] = '{3'b011, 3'b010, 1'b0, 3'b000, 3'b000};
    vecs[3] = '{3'b000, 3'b001, 1'b0, 3'b000, 3'b000};
    vecs[4] = '{3'b001, 3'b111, 1'b0, 3'b000, 3'b000};
    vecs[5] = '{3'b100, 3'b100, 1'b1, 3'b100, 3'b100};
    vecs[6] = '{3'b100, 3'b010, 1'b1, 3'b100, 3'b010};

    reset = 1'b1;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      press(vecs[i].p1, vecs[i].p2, vecs[i].valid, 12);
      check("vec_valid", {31'd0, roundValid}, {31'd0, vecs[i].valid});
      check("vec_invalid", {31'd0, invalidThrow}, {31'd0, ~vecs[i].valid});
      check("vec_p1", {29'd0, p1Latched}, {29'd0, vecs[i].e1});
      check("vec_p2", {29'd0, p2Latched}, {29'd0, vecs[i].e2});
    end

    // Bounce: 1,0,1,0 then a steady high; only the final rise counts.
    p1Throw = 3'b001;
    p2Throw = 3'b100;
    tick(3);
    playButton = 1'b1; tick(1);
    playButton = 1'b0; tick(1);
    playButton = 1'b1; tick(1);
    playButton = 1'b0; tick(1);
    playButton = 1'b1;
    sb_q.push_back('{p1: 3'b001, p2: 3'b100, edge_n: cyc + 1});
    tick(12);
    release_btn();

    // Long hold with a throw change after capture.
    p1Throw = 3'b001;
    p2Throw = 3'b010;
    tick(3);
    playButton = 1'b1;
    sb_q.push_back('{p1: 3'b001, p2: 3'b010, edge_n: cyc + 1});
    tick(20);
    p1Throw = 3'b010;
    tick(30);
    check("hold_p1_kept", {29'd0, p1Latched}, 32'd1);
    release_btn();
    check("hold_valid", {31'd0, roundValid}, 32'd1);

    // Reset three cycles into a held press; the press must re-debounce.
    p1Throw = 3'b001;
    p2Throw = 3'b100;
    tick(3);
    playButton = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    check_all_zero("midhold_reset");
    reset = 1'b0;
    sb_q.push_back('{p1: 3'b001, p2: 3'b100, edge_n: cyc + 1});
    tick(12);
    release_btn();
    check("post_reset_valid", {31'd0, roundValid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
